truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Self-checking response end of an exhaustive combinational test.
- Drives all 2^N_IN input vectors into a combinational gate under test, in ascending order.
- Holds each vector for DWELL cycles, then samples the gate's single-bit output and compares it against an expected truth table.
- Reports the captured table, the mismatch count, the first failing vector and pass/fail, so a board-level gate check needs no simulator.

Parameters:
- N_IN, 4, number of gate inputs; legal range 1..6.
- DWELL, 100, clock cycles each vector is held before sampling; must be >= 1.
- EXPECTED, 16'h7FFF, expected output per vector; bit i is the expected y for vec == i; width 2^N_IN (default is the NAND4 table).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run when the FSM is in IDLE or DONE.
- vec  out  N_IN  stimulus vector to the gate under test.
- y_in  in  1  gate output; sampled only on the last dwell cycle.
- busy  out  1  high while in DRIVE.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  high in DONE when err_count == 0; low otherwise.
- err_count  out  N_IN+1  number of mismatching vectors; range 0..2^N_IN, so it never saturates.
- first_fail  out  N_IN  index of the lowest mismatching vector; valid when done=1 and pass=0.
- captured  out  2^N_IN  sampled outputs; bit i holds y_in observed for vec == i.

Behaviour:
- Reset, or any cycle with rst=1, including mid-run:
  - state=IDLE, vec=0, dwell counter=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail=0, captured=0.
  - rst has priority over start.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs are held at their reset values.
  - start=1 -> DRIVE on the next edge.
  - On that edge: vec=0, dwell counter=0, err_count=0, captured=0, first_fail=0.
- DRIVE:
  - busy=1. The dwell counter increments every cycle.
  - While counter < DWELL-1: vec is held.
  - On the cycle with counter == DWELL-1 (sample cycle):
    - captured[vec] <= y_in.
    - If y_in != EXPECTED[vec]: err_count increments; if this is the first mismatch of the run, first_fail <= vec.
    - If vec == 2^N_IN-1: next state is DONE.
    - Otherwise: vec increments and the counter clears.
  - start is ignored while in DRIVE.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - vec holds the final value 2^N_IN-1.
  - Results are held.
  - start=1 re-enters DRIVE with the same clearing as from IDLE. done drops on that edge.
- Timing:
  - Each vector is presented for exactly DWELL cycles.
  - Latency from the start edge to done=1 is 2^N_IN*DWELL + 1 cycles.
  - y_in is sampled DWELL-1 cycles after vec changes.
  - The gate path must settle within DWELL-1 cycles; with DWELL=1 it settles within the same cycle.
- Widths:
  - The dwell counter is clog2(DWELL+1) bits and compares against DWELL-1. No wrap occurs before the compare.
  - vec never wraps; the final increment is suppressed.
- All outputs are registered; there is no combinational path from y_in to any output.

Decomposition:
- Shared package tt_check_pkg:
  - State encoding localparams: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2.
  - Function clog2.
- One natural sub-module, dwell_timer:
  - Inputs: clk, rst, clear.
  - Output: a tick asserted on count == DWELL-1.
  - Parameter: DWELL.
- The FSM, capture and compare logic stay in truth_table_checker.

Test Plan:
- Defaults with a NAND4 model on vec -> y_in; pulse start -> done=1 at cycle 1601 after start, pass=1, err_count=0, captured=16'h7FFF.
- Faulty gate (y_in forced to 1 when vec==4'hF) -> err_count=1, first_fail=4'hF, pass=0, captured=16'hFFFF.
- Stuck-at-0 y_in -> err_count=15, first_fail=0, captured=16'h0000, pass=0.
- DWELL=1, N_IN=2, EXPECTED=4'b0111, NAND2 model -> vec steps 0,1,2,3 on consecutive cycles, done 5 cycles after start, pass=1.
- rst asserted while vec==4'h7 in a run -> next cycle all outputs are at reset values; a start pulse during that rst cycle is ignored.
- start pulsed mid-run -> no effect on vec or timing; start in DONE -> rerun; done falls next cycle, err_count clears to 0.

Source files
------------

// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table checker slice.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/truth_table_checker_dwell_timer.sv
// Free-running dwell counter with synchronous clear; tick marks the last dwell cycle.
module dwell_timer
  import tt_check_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a gate under test, samples its output after a dwell
// and compares it against an expected truth table.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned            N_IN     = 4,
  parameter int unsigned            DWELL    = 100,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 16'h7FFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        vec,
  input  logic                   y_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_fail,
  output logic [(1<<N_IN)-1:0]   captured
);

  localparam int unsigned NV  = 1 << N_IN;
  localparam int unsigned ECW = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

  tt_state_e         state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     err_count_q, err_count_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic [NV-1:0]     captured_q, captured_d;
  logic              tick;
  logic              timer_clear;

  // Counter runs only in DRIVE and restarts at every vector boundary.
  assign timer_clear = (state_q != DRIVE) || tick;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    captured_d   = captured_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = DRIVE;
          vec_d        = '0;
          err_count_d  = '0;
          first_fail_d = '0;
          captured_d   = '0;
        end
      end
      DRIVE: begin
        if (tick) begin
          captured_d[vec_q] = y_in;
          if (y_in != EXPECTED[vec_q]) begin
            err_count_d = err_count_q + ECW'(1);
            if (err_count_q == '0) first_fail_d = vec_q;
          end
          if (vec_q == LAST_VEC) state_d = DONE;
          else                   vec_d   = vec_q + N_IN'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      captured_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      captured_q   <= captured_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = (state_q == DRIVE);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_count_q == '0);
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign captured   = captured_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: default NAND4 checker plus a DWELL=1 NAND2 instance.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start2;
  int unsigned mode;

  logic [3:0]  vec;
  logic        y_in;
  logic        busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [15:0] captured;

  logic [1:0]  vec2;
  logic        y2;
  logic        busy2, done2, pass2;
  logic [2:0]  err2;
  logic [1:0]  first2;
  logic [3:0]  captured2;

  int unsigned checks_total  = 0;
  int unsigned checks_passed = 0;

  always #5 clk = ~clk;

  // Gate models: 0 = NAND4, 1 = NAND4 with vec F stuck high, 2 = stuck-at-0.
  always_comb begin
    case (mode)
      0:       y_in = ~&vec;
      1:       y_in = (~&vec) | (vec == 4'hF);
      default: y_in = 1'b0;
    endcase
  end
  assign y2 = ~&vec2;

  truth_table_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec        (vec),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .captured   (captured)
  );

  truth_table_checker #(
    .N_IN     (2),
    .DWELL    (1),
    .EXPECTED (4'b0111)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .vec        (vec2),
    .y_in       (y2),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .err_count  (err2),
    .first_fail (first2),
    .captured   (captured2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             checks_passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start and counts edges (start edge = 1) until done; optional extra start mid-run.
  task automatic run(input int mid_start_at, output int lat);
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      if (lat == mid_start_at) start = 1'b1;
      step();
      start = 1'b0;
      lat++;
    end
  endtask

  int lat;
  int guard;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    mode   = 0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_vec",      32'(vec),        32'h0);
    check("rst_busy",     32'(busy),       32'h0);
    check("rst_done",     32'(done),       32'h0);
    check("rst_err",      32'(err_count),  32'h0);
    check("rst_captured", 32'(captured),   32'h0);

    // Good NAND4
    run(-1, lat);
    check("nand4_latency",  32'(lat),       32'd1601);
    check("nand4_pass",     32'(pass),      32'h1);
    check("nand4_err",      32'(err_count), 32'h0);
    check("nand4_captured", 32'(captured),  32'h7FFF);
    check("nand4_vec_end",  32'(vec),       32'hF);
    check("nand4_busy",     32'(busy),      32'h0);

    // Stuck-at-0
    mode = 2;
    run(-1, lat);
    check("s0_latency",  32'(lat),        32'd1601);
    check("s0_err",      32'(err_count),  32'd15);
    check("s0_first",    32'(first_fail), 32'h0);
    check("s0_captured", 32'(captured),   32'h0000);
    check("s0_pass",     32'(pass),       32'h0);

    // Rerun from DONE with the faulty gate, plus a stray start mid-run
    mode  = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("rerun_done_drop", 32'(done),      32'h0);
    check("rerun_err_clear", 32'(err_count), 32'h0);
    check("rerun_busy",      32'(busy),      32'h1);
    lat = 1;
    while (!done && lat < 3000) begin
      if (lat == 350) start = 1'b1;
      step();
      start = 1'b0;
      lat++;
    end
    check("fault_latency",  32'(lat),        32'd1601);
    check("fault_err",      32'(err_count),  32'd1);
    check("fault_first",    32'(first_fail), 32'hF);
    check("fault_pass",     32'(pass),       32'h0);
    check("fault_captured", 32'(captured),   32'hFFFF);

    // Reset mid-run at vec 7, with start asserted in the same cycle
    mode  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (vec != 4'h7 && guard < 3000) begin
      step();
      guard++;
    end
    check("reach_vec7", 32'(vec), 32'h7);
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("midrst_vec",      32'(vec),        32'h0);
    check("midrst_busy",     32'(busy),       32'h0);
    check("midrst_done",     32'(done),       32'h0);
    check("midrst_pass",     32'(pass),       32'h0);
    check("midrst_err",      32'(err_count),  32'h0);
    check("midrst_first",    32'(first_fail), 32'h0);
    check("midrst_captured", 32'(captured),   32'h0);
    step();
    step();
    check("midrst_start_ignored", 32'(busy), 32'h0);

    // DWELL=1 NAND2 instance
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("n2_vec0", 32'(vec2),  32'h0);
    check("n2_busy", 32'(busy2), 32'h1);
    step();
    check("n2_vec1", 32'(vec2), 32'h1);
    step();
    check("n2_vec2", 32'(vec2), 32'h2);
    step();
    check("n2_vec3",       32'(vec2),  32'h3);
    check("n2_done_early", 32'(done2), 32'h0);
    step();
    check("n2_done",     32'(done2),     32'h1);
    check("n2_pass",     32'(pass2),     32'h1);
    check("n2_err",      32'(err2),      32'h0);
    check("n2_captured", 32'(captured2), 32'h7);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
